// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency, single-ported memory between instruction fetch and
// the MEM-stage data port. Data requests win, except that fetch is forced through after
// MAX_STARVE consecutive losses to data.
module mem_arbiter #(
    parameter int LAT        = 2,
    parameter int MAX_STARVE = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  wait_cnt, wait_cnt_n;
    logic [3:0]  starve_cnt, starve_cnt_n;
    logic        owner, owner_n;          // 1 = data port owns the current transaction
    logic        own_we, own_we_n;
    logic        mem_en_n, mem_we_n, if_ack_n, d_ack_n, busy_n;
    logic [31:0] mem_addr_n, mem_wdata_n, if_rdata_n, d_rdata_n;
    logic        fetch_win;
    logic [31:0] sel_addr;
    logic        unused_addr_bits;

    // Byte-offset bits are dropped: only word-aligned accesses are supported.
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0], sel_addr[1:0]};

    assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

    assign fetch_win = if_req & (~d_req | (starve_cnt >= 4'(MAX_STARVE)));
    assign sel_addr  = fetch_win ? if_addr : d_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            owner      <= 1'b0;
            own_we     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            wait_cnt   <= wait_cnt_n;
            starve_cnt <= starve_cnt_n;
            owner      <= owner_n;
            own_we     <= own_we_n;
            mem_en     <= mem_en_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            if_ack     <= if_ack_n;
            d_ack      <= d_ack_n;
            if_rdata   <= if_rdata_n;
            d_rdata    <= d_rdata_n;
            busy       <= busy_n;
        end
    end

    always_comb begin
        state_n      = state;
        wait_cnt_n   = wait_cnt;
        starve_cnt_n = starve_cnt;
        owner_n      = owner;
        own_we_n     = own_we;
        mem_en_n     = mem_en;
        mem_we_n     = mem_we;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        if_ack_n     = 1'b0;
        d_ack_n      = 1'b0;
        if_rdata_n   = if_rdata;
        d_rdata_n    = d_rdata;
        busy_n       = busy;

        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_n     = ~fetch_win;
                    own_we_n    = fetch_win ? 1'b0 : d_we;
                    mem_en_n    = 1'b1;
                    mem_we_n    = fetch_win ? 1'b0 : d_we;
                    mem_addr_n  = {2'b00, sel_addr[31:2]};
                    mem_wdata_n = fetch_win ? 32'h0 : d_wdata;
                    busy_n      = 1'b1;
                    wait_cnt_n  = '0;
                    state_n     = ACCESS;
                    // Only a loss to data while fetch is waiting counts as starvation.
                    if (fetch_win)
                        starve_cnt_n = '0;
                    else if (if_req)
                        starve_cnt_n = starve_cnt + 4'd1;
                end
            end
            ACCESS: begin
                mem_we_n   = 1'b0;
                wait_cnt_n = wait_cnt + 4'd1;
                if (wait_cnt == 4'(LAT - 1)) begin
                    mem_en_n = 1'b0;
                    state_n  = RESP;
                    if (owner) begin
                        d_ack_n   = 1'b1;
                        d_rdata_n = own_we ? 32'h0 : mem_rdata;
                    end else begin
                        if_ack_n   = 1'b1;
                        if_rdata_n = mem_rdata;
                    end
                end
            end
            RESP: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
